oclib_button_events: RTL and testbench
======================================

// Module: oclib_button_events
//
// PURPOSE
// Classifies a clean, already-debounced button level into one-cycle event pulses:
// press, release, short press, long press, double click, and auto-repeat while held.
// It sits directly downstream of the debounce stage, whose output drives 'in'.
// Its outputs go to CSR/UI logic.
// Thresholds are parameters in clock cycles, so the block is clock-rate agnostic.
//
// PARAMETERS
// LongCycles    default 1000  consecutive high samples that qualify a long press (>=2)
// DoubleCycles  default 300   max low samples between releases/presses for a double click (>=1)
// RepeatCycles  default 200   repeat period while held after a long press; 0 disables repeat
// CounterW      derived       $clog2(max(LongCycles,DoubleCycles,RepeatCycles)+1); localparam
//
// PORTS
// clock         input   1  clock
// resetN        input   1  reset, synchronous, active-low
// in            input   1  debounced button level, 1 = pressed; already synchronous to clock
// pressPulse    output  1  1-cycle pulse on each accepted press
// releasePulse  output  1  1-cycle pulse on each release of an accepted press
// shortPress    output  1  1-cycle pulse: single press released before long, no 2nd press in window
// longPress     output  1  1-cycle pulse: held for LongCycles samples
// doubleClick   output  1  1-cycle pulse: second press started within DoubleCycles of a short release
// repeatPulse   output  1  1-cycle pulse every RepeatCycles samples while held in LONG
// held          output  1  level: state is PRESSED, PRESSED2 or LONG
//
// BEHAVIOUR
// - All outputs are registered. Each output reflects the 'in' sample of the previous edge (latency 1).
// - All pulses are exactly 1 cycle wide. More than one pulse may assert in the same cycle.
// - Reset (resetN=0 sampled at edge): all outputs 0, counter 0, state ARM.
// - Reset mid-operation aborts any pending event. No pulse is issued for it.
// - One CounterW counter saturates at all-ones. It is cleared on every state change.
// - ARM: waits for in=0, then goes to IDLE. A button already held at reset therefore produces no events.
// - IDLE: on in=1, go to PRESSED and assert pressPulse.
// - PRESSED: counter counts high samples.
//   - in=0: assert releasePulse and go to WAIT2.
//   - in=1 and this is the LongCycles-th high sample: assert longPress and go to LONG.
//   - Release takes priority. in=0 can only arrive after at most LongCycles-1 highs.
// - LONG: in=1 with RepeatCycles!=0: assert repeatPulse on every RepeatCycles-th sample, counter wraps to 0.
//   in=0: assert releasePulse and go to IDLE. No shortPress is issued.
// - WAIT2: counter counts low samples.
//   - in=1 before the DoubleCycles-th low sample: assert pressPulse and doubleClick, go to PRESSED2.
//   - On the DoubleCycles-th low sample: assert shortPress and go to IDLE.
//   - If in=1 arrives on the same sample, the doubleClick path wins.
// - PRESSED2: counts highs.
//   - in=0: assert releasePulse and go to IDLE.
//   - LongCycles-th high: assert longPress and go to LONG.
// - held=1 in PRESSED, PRESSED2 and LONG. It updates on the same edge as the state.
// - No combinational path from in to any output.
//
// TESTING (LongCycles=8, DoubleCycles=5, RepeatCycles=4)
// - in=1 during reset, resetN released with in held 20 cycles, then in=0:
//   no pulses at all; held stays 0.
// - in=1 for 3 cycles, then 0:
//   pressPulse 1 cycle after rise; releasePulse 1 cycle after fall;
//   shortPress 5 cycles after releasePulse; no other pulses.
// - in=1 for 3, 0 for 2, 1 for 2, 0:
//   pressPulse, releasePulse, then pressPulse+doubleClick together, then releasePulse; no shortPress.
// - in=1 for 20 cycles:
//   longPress after 8th high sample; repeatPulse at high samples 12,16,20;
//   releasePulse after fall; held high throughout.
// - in=1 for 7 cycles, then 0:
//   no longPress; releasePulse, then shortPress (release wins over the long threshold).
// - resetN=0 for 1 cycle in WAIT2 (after a short release):
//   no shortPress emitted; all outputs 0 after the reset edge; next press behaves from IDLE.

Source files
------------

// File: rtl/oclib_button_events.sv
// Turns a debounced button level into one-cycle event pulses
// (press, release, short, long, double click, auto-repeat) plus a held level.
module oclib_button_events #(
  parameter int LongCycles   = 1000,
  parameter int DoubleCycles = 300,
  parameter int RepeatCycles = 200
) (
  input  logic clock,
  input  logic resetN,
  input  logic in,
  output logic pressPulse,
  output logic releasePulse,
  output logic shortPress,
  output logic longPress,
  output logic doubleClick,
  output logic repeatPulse,
  output logic held
);

  localparam int MaxLD     = (LongCycles > DoubleCycles) ? LongCycles : DoubleCycles;
  localparam int MaxCycles = (MaxLD > RepeatCycles) ? MaxLD : RepeatCycles;
  localparam int CounterW  = $clog2(MaxCycles + 1);

  // The high sample that enters PRESSED/PRESSED2 is the first high, so the
  // long threshold is reached when the in-state count sits at LongCycles-2.
  localparam logic [CounterW-1:0] LongLast   = CounterW'(LongCycles - 2);
  localparam logic [CounterW-1:0] DoubleLast = CounterW'(DoubleCycles - 1);
  localparam logic [CounterW-1:0] RepeatLast =
    CounterW'((RepeatCycles == 0) ? 0 : RepeatCycles - 1);

  typedef enum logic [2:0] {
    ARM,
    IDLE,
    PRESSED,
    WAIT2,
    PRESSED2,
    LONG
  } state_t;

  state_t                r_state;
  logic [CounterW-1:0]   r_count;
  logic [CounterW-1:0]   w_countInc;

  assign w_countInc = (r_count == '1) ? r_count : r_count + CounterW'(1);

  always_ff @(posedge clock) begin
    pressPulse   <= 1'b0;
    releasePulse <= 1'b0;
    shortPress   <= 1'b0;
    longPress    <= 1'b0;
    doubleClick  <= 1'b0;
    repeatPulse  <= 1'b0;
    if (!resetN) begin
      r_state <= ARM;
      r_count <= '0;
      held    <= 1'b0;
    end else begin
      case (r_state)
        ARM: begin
          held <= 1'b0;
          if (!in) begin
            r_state <= IDLE;
            r_count <= '0;
          end
        end
        IDLE: begin
          held <= 1'b0;
          if (in) begin
            r_state    <= PRESSED;
            r_count    <= '0;
            pressPulse <= 1'b1;
            held       <= 1'b1;
          end
        end
        PRESSED: begin
          held <= 1'b1;
          if (!in) begin
            r_state      <= WAIT2;
            r_count      <= '0;
            releasePulse <= 1'b1;
            held         <= 1'b0;
          end else if (r_count == LongLast) begin
            r_state   <= LONG;
            r_count   <= '0;
            longPress <= 1'b1;
          end else begin
            r_count <= w_countInc;
          end
        end
        WAIT2: begin
          held <= 1'b0;
          // Any high while waiting is a second press, even on the timeout sample.
          if (in) begin
            r_state     <= PRESSED2;
            r_count     <= '0;
            pressPulse  <= 1'b1;
            doubleClick <= 1'b1;
            held        <= 1'b1;
          end else if (r_count == DoubleLast) begin
            r_state    <= IDLE;
            r_count    <= '0;
            shortPress <= 1'b1;
          end else begin
            r_count <= w_countInc;
          end
        end
        PRESSED2: begin
          held <= 1'b1;
          if (!in) begin
            r_state      <= IDLE;
            r_count      <= '0;
            releasePulse <= 1'b1;
            held         <= 1'b0;
          end else if (r_count == LongLast) begin
            r_state   <= LONG;
            r_count   <= '0;
            longPress <= 1'b1;
          end else begin
            r_count <= w_countInc;
          end
        end
        LONG: begin
          held <= 1'b1;
          if (!in) begin
            r_state      <= IDLE;
            r_count      <= '0;
            releasePulse <= 1'b1;
            held         <= 1'b0;
          end else if (RepeatCycles != 0 && r_count == RepeatLast) begin
            r_count     <= '0;
            repeatPulse <= 1'b1;
          end else begin
            r_count <= w_countInc;
          end
        end
        default: begin
          r_state <= ARM;
          r_count <= '0;
          held    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oclib_button_events.sv
// Directed bench for oclib_button_events with LongCycles=8, DoubleCycles=5, RepeatCycles=4.
// Observed vector order: {press, release, short, long, double, repeat, held}.
module tb_oclib_button_events;

  logic clock = 1'b0;
  logic resetN;
  logic in;
  logic pressPulse, releasePulse, shortPress, longPress, doubleClick, repeatPulse, held;
  logic [6:0] obs;

  int checks = 0;
  int errors = 0;

  oclib_button_events #(
    .LongCycles  (8),
    .DoubleCycles(5),
    .RepeatCycles(4)
  ) dut (
    .clock       (clock),
    .resetN      (resetN),
    .in          (in),
    .pressPulse  (pressPulse),
    .releasePulse(releasePulse),
    .shortPress  (shortPress),
    .longPress   (longPress),
    .doubleClick (doubleClick),
    .repeatPulse (repeatPulse),
    .held        (held)
  );

  always #5 clock = ~clock;

  assign obs = {pressPulse, releasePulse, shortPress, longPress, doubleClick, repeatPulse, held};

  // Apply one input sample and reset level, then settle just after the edge.
  task automatic tick(input logic v, input logic rn);
    @(negedge clock);
    in     = v;
    resetN = rn;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    checks++;
    if (obs !== 7'b0000000) begin
      errors++;
      $display("FAIL reset_state: got %b expected %b", obs, 7'b0000000);
    end
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 1'b1);
      checks++;
      if (obs !== 7'b0000000) begin
        errors++;
        $display("FAIL held_at_reset step %0d: got %b expected %b", i, obs, 7'b0000000);
      end
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1);
      checks++;
      if (obs !== 7'b0000000) begin
        errors++;
        $display("FAIL arm_release step %0d: got %b expected %b", i, obs, 7'b0000000);
      end
    end
  endtask

  task automatic test_short();
    logic [9:0] vin = 10'b1110000000;
    logic [6:0] ex [10] = '{7'b1000001, 7'b0000001, 7'b0000001, 7'b0100000, 7'b0000000,
                            7'b0000000, 7'b0000000, 7'b0000000, 7'b0010000, 7'b0000000};
    for (int i = 0; i < 10; i++) begin
      tick(vin[9-i], 1'b1);
      checks++;
      if (obs !== ex[i]) begin
        errors++;
        $display("FAIL short_press step %0d: got %b expected %b", i, obs, ex[i]);
      end
    end
  endtask

  task automatic test_double();
    logic [13:0] vin = 14'b11100110000000;
    logic [6:0] ex [14] = '{7'b1000001, 7'b0000001, 7'b0000001, 7'b0100000, 7'b0000000,
                            7'b1000101, 7'b0000001, 7'b0100000, 7'b0000000, 7'b0000000,
                            7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000};
    for (int i = 0; i < 14; i++) begin
      tick(vin[13-i], 1'b1);
      checks++;
      if (obs !== ex[i]) begin
        errors++;
        $display("FAIL double_click step %0d: got %b expected %b", i, obs, ex[i]);
      end
    end
  endtask

  task automatic test_long();
    logic [6:0] ex;
    for (int i = 1; i <= 27; i++) begin
      if (i <= 20) begin
        ex = 7'b0000001;
        if (i == 1) ex = 7'b1000001;
        if (i == 8) ex = 7'b0001001;
        if (i == 12 || i == 16 || i == 20) ex = 7'b0000011;
      end else if (i == 21) begin
        ex = 7'b0100000;
      end else begin
        ex = 7'b0000000;
      end
      tick((i <= 20) ? 1'b1 : 1'b0, 1'b1);
      checks++;
      if (obs !== ex) begin
        errors++;
        $display("FAIL long_repeat high %0d: got %b expected %b", i, obs, ex);
      end
    end
  endtask

  task automatic test_seven();
    logic [13:0] vin = 14'b11111110000000;
    logic [6:0] ex [14] = '{7'b1000001, 7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001,
                            7'b0000001, 7'b0000001, 7'b0100000, 7'b0000000, 7'b0000000,
                            7'b0000000, 7'b0000000, 7'b0010000, 7'b0000000};
    for (int i = 0; i < 14; i++) begin
      tick(vin[13-i], 1'b1);
      checks++;
      if (obs !== ex[i]) begin
        errors++;
        $display("FAIL below_long step %0d: got %b expected %b", i, obs, ex[i]);
      end
    end
  endtask

  task automatic test_reset_wait2();
    logic [5:0] pre = 6'b111000;
    logic [6:0] exPre [6] = '{7'b1000001, 7'b0000001, 7'b0000001, 7'b0100000,
                              7'b0000000, 7'b0000000};
    logic [6:0] exPost [7] = '{7'b1000001, 7'b0100000, 7'b0000000, 7'b0000000,
                               7'b0000000, 7'b0000000, 7'b0010000};
    for (int i = 0; i < 6; i++) begin
      tick(pre[5-i], 1'b1);
      checks++;
      if (obs !== exPre[i]) begin
        errors++;
        $display("FAIL wait2_setup step %0d: got %b expected %b", i, obs, exPre[i]);
      end
    end
    tick(1'b0, 1'b0);
    checks++;
    if (obs !== 7'b0000000) begin
      errors++;
      $display("FAIL wait2_reset: got %b expected %b", obs, 7'b0000000);
    end
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'b1);
      checks++;
      if (obs !== 7'b0000000) begin
        errors++;
        $display("FAIL wait2_aborted step %0d: got %b expected %b", i, obs, 7'b0000000);
      end
    end
    for (int i = 0; i < 7; i++) begin
      tick((i == 0) ? 1'b1 : 1'b0, 1'b1);
      checks++;
      if (obs !== exPost[i]) begin
        errors++;
        $display("FAIL after_reset step %0d: got %b expected %b", i, obs, exPost[i]);
      end
    end
  endtask

  initial begin
    resetN = 1'b0;
    in     = 1'b0;
    test_reset();
    test_short();
    test_double();
    test_long();
    test_seven();
    test_reset_wait2();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
